vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates raster timing for the display pipeline: the hcounter/vcounter pixel coordinates, plus hsync, vsync and blanking.
- It is the producer side of the coordinate interface read by every draw_* renderer and by the colour mux.
- All outputs are registered and mutually aligned. A renderer sampling hcounter/vcounter in cycle N sees hsync, vsync and active for that same coordinate in cycle N.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 56, horizontal front porch in pixels
- H_SYNC, 120, hsync pulse width in pixels
- H_BP, 64, horizontal back porch in pixels
- V_ACTIVE, 600, visible lines per frame
- V_FP, 37, vertical front porch in lines
- V_SYNC, 6, vsync pulse width in lines
- V_BP, 23, vertical back porch in lines
- H_POL, 1, hsync active level (1 = active-high)
- V_POL, 1, vsync active level
- CLK_DIV, 1, clock cycles per pixel (1..4)

Ports:
- clk  input  1  system clock (50 MHz)
- rst_n  input  1  synchronous active-low reset
- hcounter  output  12  current pixel column, 0..H_TOTAL-1
- vcounter  output  11  current line, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, polarity H_POL
- vsync  output  1  vertical sync, polarity V_POL
- active  output  1  high when hcounter<H_ACTIVE and vcounter<V_ACTIVE
- pix_tick  output  1  one-cycle pulse in each cycle where the counters advance
- line_start  output  1  one-cycle pulse coincident with hcounter becoming 0
- frame_start  output  1  one-cycle pulse coincident with (hcounter,vcounter) becoming (0,0)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1040); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 666). Defaults give 800x600 at 72 Hz from 50 MHz.
- Reset (rst_n low at a clk edge):
  - hcounter=0, vcounter=0, hsync=~H_POL, vsync=~V_POL.
  - active=1, because (0,0) is visible.
  - pix_tick=0, line_start=0, frame_start=0.
  - Divider counter cleared.
  - Reset asserted mid-frame takes effect on that edge; no partial line completes.
- Divider:
  - Internal counter runs 0..CLK_DIV-1.
  - The tick fires on the edge where it wraps to 0.
  - With CLK_DIV=1 every cycle ticks.
  - First tick occurs CLK_DIV cycles after the first clk edge with rst_n high.
- Counter advance happens only on tick edges:
  - hcounter increments.
  - At H_TOTAL-1, hcounter wraps to 0 and vcounter increments.
  - At (H_TOTAL-1, V_TOTAL-1) both wrap to 0.
  - hcounter never reaches H_TOTAL; vcounter never reaches V_TOTAL.
- Sync and blanking outputs are computed from the next counter values and registered on the same edge, so they match the counter outputs with zero relative latency:
  - hsync = H_POL when H_ACTIVE+H_FP <= hcounter < H_ACTIVE+H_FP+H_SYNC, else ~H_POL.
  - vsync = V_POL when V_ACTIVE+V_FP <= vcounter < V_ACTIVE+V_FP+V_SYNC, else ~V_POL.
  - vsync changes only together with hcounter becoming 0.
- Pulses:
  - pix_tick is high for the cycle following each tick edge.
  - line_start and frame_start are high for exactly one cycle (not CLK_DIV cycles), in the cycle after the edge that produced hcounter=0 or (0,0) respectively.
  - frame_start implies line_start.
  - No pulses are generated by reset itself.
- Between ticks (CLK_DIV>1) all outputs except the pulses hold their values.
- Widths:
  - All comparisons use unsigned arithmetic at counter width.
  - Parameter sums must fit: H_TOTAL <= 4095, V_TOTAL <= 2047.
  - Outputs are undefined if this is violated; the bench checks defaults and one alternate set only.

Test Plan:
- Reset, then release with defaults → hcounter counts 0,1,2… every cycle; first line_start when hcounter returns to 0 after 1040 cycles, with vcounter=1.
- Horizontal sync, defaults → hsync high exactly for hcounter 856..975 (120 cycles per line); active low for hcounter 800..1039.
- Full frame, defaults → vsync high for vcounter 637..642; frame_start pulses every 1040*666 = 692640 cycles, coincident with hcounter=0, vcounter=0, active=1.
- CLK_DIV=2, H_POL=0, V_POL=0 → counters advance every 2nd cycle; pix_tick has 50% duty; hsync idles high and pulses low at hcounter 856..975 (240 clk cycles); line_start is 1 cycle wide.
- Reset asserted at hcounter=500, vcounter=300 → next edge outputs hcounter=0, vcounter=0, active=1, sync inactive, no pulses; counting restarts cleanly.
- Alternate timing H_ACTIVE=640,H_FP=16,H_SYNC=96,H_BP=48,V_ACTIVE=480,V_FP=10,V_SYNC=2,V_BP=33 → max hcounter 799, max vcounter 524; hsync at hcounter 656..751, vsync at vcounter 490..491.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters with registered, mutually aligned
// sync, blanking and start-of-line/frame pulses.
module vga_timing_gen #(
   parameter int H_ACTIVE = 800,
   parameter int H_FP     = 56,
   parameter int H_SYNC   = 120,
   parameter int H_BP     = 64,
   parameter int V_ACTIVE = 600,
   parameter int V_FP     = 37,
   parameter int V_SYNC   = 6,
   parameter int V_BP     = 23,
   parameter bit H_POL    = 1'b1,
   parameter bit V_POL    = 1'b1,
   parameter int CLK_DIV  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [11:0] hcounter,
   output logic [10:0] vcounter,
   output logic        hsync,
   output logic        vsync,
   output logic        active,
   output logic        pix_tick,
   output logic        line_start,
   output logic        frame_start
);

   localparam logic [11:0] H_MAX    = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [11:0] H_VIS    = 12'(H_ACTIVE);
   localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] V_MAX    = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
   localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [1:0]  DIV_MAX  = 2'(CLK_DIV - 1);

   logic [1:0]  div_cnt;
   logic [1:0]  div_next;
   logic        tick;
   logic [11:0] h_next;
   logic [10:0] v_next;

   // Divider and next-coordinate computation; outputs are derived from the next
   // values so they land in the same cycle as the counters themselves.
   always_comb begin
      tick     = (div_cnt == DIV_MAX);
      div_next = div_cnt + 2'd1;
      h_next   = hcounter;
      v_next   = vcounter;
      if (tick) begin
         div_next = 2'd0;
         if (hcounter == H_MAX) begin
            h_next = 12'd0;
            if (vcounter == V_MAX) begin
               v_next = 11'd0;
            end else begin
               v_next = vcounter + 11'd1;
            end
         end else begin
            h_next = hcounter + 12'd1;
         end
      end else begin
         div_next = div_cnt + 2'd1;
      end
   end

   // Registered timing state; reset lands on (0,0), which is visible.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_cnt     <= 2'd0;
         hcounter    <= 12'd0;
         vcounter    <= 11'd0;
         hsync       <= ~H_POL;
         vsync       <= ~V_POL;
         active      <= 1'b1;
         pix_tick    <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         div_cnt     <= div_next;
         hcounter    <= h_next;
         vcounter    <= v_next;
         hsync       <= ((h_next >= HS_START) && (h_next < HS_END)) ? H_POL : ~H_POL;
         vsync       <= ((v_next >= VS_START) && (v_next < VS_END)) ? V_POL : ~V_POL;
         active      <= (h_next < H_VIS) && (v_next < V_VIS);
         pix_tick    <= tick;
         line_start  <= tick && (h_next == 12'd0);
         frame_start <= tick && (h_next == 12'd0) && (v_next == 11'd0);
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing, divided/inverted-polarity
// timing, 640x480 horizontal timing and short-line instances for vertical timing.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   logic [11:0] a_h, b_h, c_h, d_h, e_h;
   logic [10:0] a_v, b_v, c_v, d_v, e_v;
   logic a_hs, a_vs, a_act, a_pt, a_ls, a_fs;
   logic b_hs, b_vs, b_act, b_pt, b_ls, b_fs;
   logic c_hs, c_vs, c_act, c_pt, c_ls, c_fs;
   logic d_hs, d_vs, d_act, d_pt, d_ls, d_fs;
   logic e_hs, e_vs, e_act, e_pt, e_ls, e_fs;

   // a: defaults; b: /2 with active-low syncs; c: 640x480; d,e: 8-pixel lines
   vga_timing_gen u_a (.clk(clk), .rst_n(rst_n), .hcounter(a_h), .vcounter(a_v),
      .hsync(a_hs), .vsync(a_vs), .active(a_act), .pix_tick(a_pt),
      .line_start(a_ls), .frame_start(a_fs));
   vga_timing_gen #(.H_POL(1'b0), .V_POL(1'b0), .CLK_DIV(2)) u_b (.clk(clk),
      .rst_n(rst_n), .hcounter(b_h), .vcounter(b_v), .hsync(b_hs), .vsync(b_vs),
      .active(b_act), .pix_tick(b_pt), .line_start(b_ls), .frame_start(b_fs));
   vga_timing_gen #(.H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
      .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33)) u_c (.clk(clk),
      .rst_n(rst_n), .hcounter(c_h), .vcounter(c_v), .hsync(c_hs), .vsync(c_vs),
      .active(c_act), .pix_tick(c_pt), .line_start(c_ls), .frame_start(c_fs));
   vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33)) u_d (.clk(clk),
      .rst_n(rst_n), .hcounter(d_h), .vcounter(d_v), .hsync(d_hs), .vsync(d_vs),
      .active(d_act), .pix_tick(d_pt), .line_start(d_ls), .frame_start(d_fs));
   vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1)) u_e (.clk(clk),
      .rst_n(rst_n), .hcounter(e_h), .vcounter(e_v), .hsync(e_hs), .vsync(e_vs),
      .active(e_act), .pix_tick(e_pt), .line_start(e_ls), .frame_start(e_fs));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int hs_cnt_a = 0, hs_first_a = -1, hs_last_a = -1, act_cnt_a = 0;
   int ls_cnt_a = 0, vs_cnt_a = 0, pt_low_a = 0;
   int pt_cnt_b = 0, hs_cnt_b = 0, hs_first_b = -1, hs_last_b = -1, ls_cnt_b = 0, max_h_b = 0;
   int hs_cnt_c = 0, hs_first_c = -1, hs_last_c = -1, max_h_c = 0;
   int vs_cnt_d = 0, vs_first_d = -1, vs_last_d = -1, max_v_d = 0, fs_cnt_d = 0;
   int vs_cnt_e = 0, vs_first_e = -1, vs_last_e = -1, fs_cnt_e = 0;
   int fs_no_ls = 0, vs_mid_line = 0;
   logic prev_vs_d, prev_vs_e;
   bit found;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_a_h", a_h, 0);        chk("rst_a_v", a_v, 0);
      chk("rst_a_hs", a_hs, 0);      chk("rst_a_vs", a_vs, 0);
      chk("rst_a_act", a_act, 1);    chk("rst_a_pt", a_pt, 0);
      chk("rst_a_ls", a_ls, 0);      chk("rst_a_fs", a_fs, 0);
      chk("rst_b_hs", b_hs, 1);      chk("rst_b_vs", b_vs, 1);

      rst_n = 1'b1;
      step();
      chk("k1_a_h", a_h, 1);         chk("k1_a_pt", a_pt, 1);
      chk("k1_a_ls", a_ls, 0);       chk("k1_b_h", b_h, 0);
      chk("k1_b_pt", b_pt, 0);
      step();
      chk("k2_a_h", a_h, 2);         chk("k2_b_h", b_h, 1);
      chk("k2_b_pt", b_pt, 1);
      prev_vs_d = d_vs;
      prev_vs_e = e_vs;

      for (int k = 3; k <= 5400; k++) begin
         step();
         if (k >= 1040 && k <= 2079) begin
            if (a_hs) begin
               hs_cnt_a++;
               if (hs_first_a < 0) hs_first_a = int'(a_h);
               hs_last_a = int'(a_h);
            end
            if (a_act) act_cnt_a++;
         end
         if (a_ls) ls_cnt_a++;
         if (a_vs) vs_cnt_a++;
         if (!a_pt) pt_low_a++;

         if (b_pt) pt_cnt_b++;
         if (b_ls) ls_cnt_b++;
         if (int'(b_h) > max_h_b) max_h_b = int'(b_h);
         if (k <= 2079 && !b_hs) begin
            hs_cnt_b++;
            if (hs_first_b < 0) hs_first_b = int'(b_h);
            hs_last_b = int'(b_h);
         end

         if (int'(c_h) > max_h_c) max_h_c = int'(c_h);
         if (k <= 799 && c_hs) begin
            hs_cnt_c++;
            if (hs_first_c < 0) hs_first_c = int'(c_h);
            hs_last_c = int'(c_h);
         end

         if (d_vs) begin
            vs_cnt_d++;
            if (vs_first_d < 0) vs_first_d = int'(d_v);
            vs_last_d = int'(d_v);
         end
         if (int'(d_v) > max_v_d) max_v_d = int'(d_v);
         if (d_fs) fs_cnt_d++;
         if (e_vs) begin
            vs_cnt_e++;
            if (vs_first_e < 0) vs_first_e = int'(e_v);
            vs_last_e = int'(e_v);
         end
         if (e_fs) fs_cnt_e++;
         if ((d_fs && !d_ls) || (e_fs && !e_ls)) fs_no_ls++;
         if ((d_vs != prev_vs_d && d_h != 12'd0) || (e_vs != prev_vs_e && e_h != 12'd0))
            vs_mid_line++;
         prev_vs_d = d_vs;
         prev_vs_e = e_vs;

         if (k == 800) begin
            chk("c_wrap_h", c_h, 0);     chk("c_wrap_v", c_v, 1);
         end
         if (k == 1040) begin
            chk("a_line_h", a_h, 0);     chk("a_line_v", a_v, 1);
            chk("a_line_ls", a_ls, 1);   chk("a_line_fs", a_fs, 0);
         end
         if (k == 1041) begin
            chk("a_ls_width", a_ls, 0);  chk("a_after_h", a_h, 1);
         end
         if (k == 2080) begin
            chk("b_line_h", b_h, 0);     chk("b_line_v", b_v, 1);
            chk("b_line_ls", b_ls, 1);
         end
         if (k == 2081) begin
            chk("b_ls_width", b_ls, 0);  chk("b_hold_h", b_h, 0);
            chk("b_hold_pt", b_pt, 0);
         end
         if (k == 4200) begin
            chk("d_frame_h", d_h, 0);    chk("d_frame_v", d_v, 0);
            chk("d_frame_fs", d_fs, 1);  chk("d_frame_act", d_act, 1);
         end
         if (k == 4201) chk("d_fs_width", d_fs, 0);
         if (k == 5328) begin
            chk("e_frame_h", e_h, 0);    chk("e_frame_v", e_v, 0);
            chk("e_frame_fs", e_fs, 1);  chk("e_frame_act", e_act, 1);
         end
      end

      chk("a_hs_count", hs_cnt_a, 120);  chk("a_hs_first", hs_first_a, 856);
      chk("a_hs_last", hs_last_a, 975);  chk("a_act_count", act_cnt_a, 800);
      chk("a_ls_count", ls_cnt_a, 5);    chk("a_vs_count", vs_cnt_a, 0);
      chk("a_pt_low", pt_low_a, 0);
      chk("b_pt_count", pt_cnt_b, 2699); chk("b_hs_count", hs_cnt_b, 240);
      chk("b_hs_first", hs_first_b, 856); chk("b_hs_last", hs_last_b, 975);
      chk("b_ls_count", ls_cnt_b, 2);    chk("b_max_h", max_h_b, 1039);
      chk("c_max_h", max_h_c, 799);      chk("c_hs_count", hs_cnt_c, 96);
      chk("c_hs_first", hs_first_c, 656); chk("c_hs_last", hs_last_c, 751);
      chk("d_vs_count", vs_cnt_d, 16);   chk("d_vs_first", vs_first_d, 490);
      chk("d_vs_last", vs_last_d, 491);  chk("d_max_v", max_v_d, 524);
      chk("d_fs_count", fs_cnt_d, 1);
      chk("e_vs_count", vs_cnt_e, 48);   chk("e_vs_first", vs_first_e, 637);
      chk("e_vs_last", vs_last_e, 642);  chk("e_fs_count", fs_cnt_e, 1);
      chk("fs_without_ls", fs_no_ls, 0); chk("vs_mid_line", vs_mid_line, 0);

      // run on to a mid-frame point, then reset for a single edge
      found = 1'b0;
      for (int n = 0; n < 5000 && !found; n++) begin
         step();
         if (a_h == 12'd500 && e_v >= 11'd300) found = 1'b1;
      end
      chk("midrst_reached", found, 1);
      rst_n = 1'b0;
      step();
      chk("mr_a_h", a_h, 0);       chk("mr_a_v", a_v, 0);
      chk("mr_a_act", a_act, 1);   chk("mr_a_hs", a_hs, 0);
      chk("mr_a_pt", a_pt, 0);     chk("mr_a_ls", a_ls, 0);
      chk("mr_a_fs", a_fs, 0);     chk("mr_e_v", e_v, 0);
      chk("mr_e_vs", e_vs, 0);     chk("mr_b_hs", b_hs, 1);
      chk("mr_b_pt", b_pt, 0);
      rst_n = 1'b1;
      step();
      chk("rs1_a_h", a_h, 1);      chk("rs1_b_h", b_h, 0);
      chk("rs1_e_ls", e_ls, 0);
      step();
      chk("rs2_a_h", a_h, 2);      chk("rs2_b_h", b_h, 1);
      chk("rs2_b_pt", b_pt, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
